// File: rtl/seq_lock_pkg.sv
// seq_lock_pkg: state encoding and width helper shared by the lock design
package seq_lock_pkg;
  typedef enum logic [2:0] {
    ENTRY   = 3'd0,
    OPEN    = 3'd1,
    FAIL    = 3'd2,
    LOCKOUT = 3'd3,
    PROG    = 3'd4
  } state_t;
  function automatic int cw(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/rise_detect.sv
// rise_detect: per-bit rising-edge detector with a configurable previous-value reset
module rise_detect #(
  parameter int WIDTH = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rise
);
  logic [WIDTH-1:0] prev;
  // previous value resets high so an input held through reset gives no edge
  always_ff @(posedge clk) prev <= clr ? RST_VAL : d;
  assign rise = d & ~prev;
endmodule

// File: rtl/seq_lock.sv
// seq_lock: button-sequence lock with fail counting, timed lockout and code re-programming
module seq_lock
  import seq_lock_pkg::*;
#(
  parameter int NUM_BTN = 3,
  parameter int SEQ_LEN = 4,
  parameter logic [SEQ_LEN*cw(NUM_BTN)-1:0] DEFAULT_CODE = 8'h09,
  parameter int MAX_FAILS = 3,
  parameter int LOCKOUT_CYC = 1000
) (
  input  logic                          clk,
  input  logic                          clr,
  input  logic [NUM_BTN-1:0]            btn,
  input  logic                          check,
  input  logic                          prog,
  output logic                          blue,
  output logic                          red,
  output logic                          lockout,
  output logic [cw(SEQ_LEN+2)-1:0]      entry_cnt,
  output logic [cw(MAX_FAILS+1)-1:0]    fail_cnt
);
  localparam int IDX_W = cw(NUM_BTN);
  localparam int CW = SEQ_LEN * IDX_W;
  localparam int EW = cw(SEQ_LEN + 2);
  localparam int FW = cw(MAX_FAILS + 1);
  localparam int LW = cw(LOCKOUT_CYC);
  localparam logic [EW-1:0] LEN = EW'(SEQ_LEN);
  localparam logic [EW-1:0] SAT = EW'(SEQ_LEN + 1);
  localparam logic [EW-1:0] LAST = EW'(SEQ_LEN - 1);
  localparam logic [FW-1:0] FMAX = FW'(MAX_FAILS);
  localparam logic [LW-1:0] LEND = LW'(LOCKOUT_CYC - 1);
  state_t state;
  logic [CW-1:0] code, shadow, nshadow;
  logic [LW-1:0] lcnt;
  logic match, c_rise, p_rise, one;
  logic [NUM_BTN-1:0] b_rise;
  logic [IDX_W-1:0] idx, code_at;
  rise_detect #(.WIDTH(NUM_BTN), .RST_VAL('1)) u_btn (.clk(clk), .clr(clr), .d(btn), .rise(b_rise));
  rise_detect #(.WIDTH(1), .RST_VAL(1'b1)) u_check (.clk(clk), .clr(clr), .d(check), .rise(c_rise));
  rise_detect #(.WIDTH(1), .RST_VAL(1'b1)) u_prog (.clk(clk), .clr(clr), .d(prog), .rise(p_rise));
  assign one = $onehot(b_rise);
  // pressed index, expected code entry and shadow with the current slot overwritten
  always_comb begin
    idx = '0;
    code_at = '0;
    nshadow = shadow;
    for (int i = 0; i < NUM_BTN; i++) if (b_rise[i]) idx = IDX_W'(i);
    for (int i = 0; i < SEQ_LEN; i++) if (entry_cnt == EW'(i)) begin
      code_at = code[i*IDX_W +: IDX_W];
      nshadow[i*IDX_W +: IDX_W] = idx;
    end
  end
  // lock state machine with registered indicators and counters
  always_ff @(posedge clk) begin
    if (clr) begin
      state <= ENTRY;
      code <= DEFAULT_CODE;
      shadow <= '0;
      entry_cnt <= '0;
      fail_cnt <= '0;
      match <= 1'b1;
      lcnt <= '0;
      blue <= 1'b0;
      red <= 1'b0;
      lockout <= 1'b0;
    end else begin
      case (state)
        ENTRY: begin
          if (c_rise) begin
            if (entry_cnt == LEN && match) begin
              state <= OPEN;
              fail_cnt <= '0;
              blue <= 1'b1;
            end else if (fail_cnt + 1'b1 == FMAX) begin
              state <= LOCKOUT;
              fail_cnt <= FMAX;
              red <= 1'b1;
              lockout <= 1'b1;
              lcnt <= '0;
            end else begin
              state <= FAIL;
              fail_cnt <= fail_cnt + 1'b1;
              red <= 1'b1;
            end
          end else if (|b_rise) begin
            if (!one || entry_cnt >= LEN || idx != code_at) match <= 1'b0;
            if (entry_cnt != SAT) entry_cnt <= entry_cnt + 1'b1;
          end
        end
        OPEN: begin
          if (c_rise) begin
            state <= ENTRY;
            blue <= 1'b0;
            entry_cnt <= '0;
            match <= 1'b1;
          end else if (p_rise) begin
            state <= PROG;
            entry_cnt <= '0;
            match <= 1'b1;
          end
        end
        FAIL: begin
          if (c_rise) begin
            state <= ENTRY;
            red <= 1'b0;
            entry_cnt <= '0;
            match <= 1'b1;
          end
        end
        LOCKOUT: begin
          if (lcnt == LEND) begin
            state <= ENTRY;
            fail_cnt <= '0;
            red <= 1'b0;
            lockout <= 1'b0;
            entry_cnt <= '0;
            match <= 1'b1;
          end else lcnt <= lcnt + 1'b1;
        end
        PROG: begin
          if (c_rise) state <= OPEN;
          else if (one) begin
            shadow <= nshadow;
            if (entry_cnt == LAST) begin
              code <= nshadow;
              state <= ENTRY;
              blue <= 1'b0;
              entry_cnt <= '0;
              match <= 1'b1;
            end else entry_cnt <= entry_cnt + 1'b1;
          end
        end
        default: state <= ENTRY;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_lock.sv
// tb_seq_lock: directed scoreboard bench for the sequence lock
module tb_seq_lock;
  logic clk = 1'b0, clr = 1'b1, check = 1'b0, prog = 1'b0;
  logic [2:0] btn = '0;
  logic blue, red, lockout;
  logic [2:0] entry_cnt;
  logic [1:0] fail_cnt;
  int passed = 0, total = 0;
  typedef struct {string t; logic [7:0] e;} item_t;
  item_t sb[$];
  always #5 clk = ~clk;
  seq_lock #(.LOCKOUT_CYC(20)) dut (
    .clk(clk), .clr(clr), .btn(btn), .check(check), .prog(prog),
    .blue(blue), .red(red), .lockout(lockout), .entry_cnt(entry_cnt), .fail_cnt(fail_cnt)
  );
  function automatic logic [7:0] e(input bit b, input bit r, input bit l, input int ec, input int fc);
    return {b, r, l, 3'(ec), 2'(fc)};
  endfunction
  task automatic cmp();
    item_t it;
    logic [7:0] obs;
    it = sb.pop_front();
    obs = {blue, red, lockout, entry_cnt, fail_cnt};
    total++;
    assert (obs === it.e) passed++;
    else $error("FAIL %s observed b/r/l/ec/fc=%b required=%b", it.t, obs, it.e);
  endtask
  task automatic expect_next(input string t, input logic [7:0] x);
    sb.push_back('{t, x});
    @(negedge clk);
    cmp();
  endtask
  task automatic act(input logic [2:0] b, input logic c, input logic p, input string t, input logic [7:0] x);
    btn = b;
    check = c;
    prog = p;
    expect_next(t, x);
    repeat (2) @(negedge clk);
    btn = '0;
    check = 1'b0;
    prog = 1'b0;
    repeat (25) @(negedge clk);
  endtask
  task automatic press(input int i, input string t, input logic [7:0] x);
    act(3'(1 << i), 1'b0, 1'b0, t, x);
  endtask
  task automatic chk(input string t, input logic [7:0] x);
    act('0, 1'b1, 1'b0, t, x);
  endtask
  task automatic pulse_clr(input string t);
    clr = 1'b1;
    expect_next(t, e(0, 0, 0, 0, 0));
    clr = 1'b0;
    repeat (25) @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    clr = 1'b0;
    expect_next("reset", e(0, 0, 0, 0, 0));
    repeat (5) @(negedge clk);
    // correct default code opens, second check re-arms
    press(1, "t1_p1", e(0, 0, 0, 1, 0));
    press(2, "t1_p2", e(0, 0, 0, 2, 0));
    press(0, "t1_p3", e(0, 0, 0, 3, 0));
    press(0, "t1_p4", e(0, 0, 0, 4, 0));
    chk("t1_open", e(1, 0, 0, 4, 0));
    chk("t1_rearm", e(0, 0, 0, 0, 0));
    // wrong code, then too many presses
    press(2, "t2_p1", e(0, 0, 0, 1, 0));
    press(2, "t2_p2", e(0, 0, 0, 2, 0));
    press(1, "t2_p3", e(0, 0, 0, 3, 0));
    press(0, "t2_p4", e(0, 0, 0, 4, 0));
    chk("t2_fail1", e(0, 1, 0, 4, 1));
    chk("t2_rearm1", e(0, 0, 0, 0, 1));
    press(1, "t2_q1", e(0, 0, 0, 1, 1));
    press(2, "t2_q2", e(0, 0, 0, 2, 1));
    press(0, "t2_q3", e(0, 0, 0, 3, 1));
    press(0, "t2_q4", e(0, 0, 0, 4, 1));
    press(0, "t2_q5", e(0, 0, 0, 5, 1));
    chk("t2_fail2", e(0, 1, 0, 5, 2));
    chk("t2_rearm2", e(0, 0, 0, 0, 2));
    // third failure: lockout for exactly 20 cycles, inputs ignored
    press(0, "t3_p1", e(0, 0, 0, 1, 2));
    check = 1'b1;
    expect_next("t3_lock0", e(0, 1, 1, 1, 3));
    check = 1'b0;
    for (int i = 1; i < 20; i++) begin
      btn = (i % 4 == 1) ? 3'b010 : 3'b000;
      check = (i % 4 == 2);
      expect_next($sformatf("t3_lock%0d", i), e(0, 1, 1, 1, 3));
    end
    btn = '0;
    check = 1'b0;
    expect_next("t3_exit", e(0, 0, 0, 0, 0));
    repeat (25) @(negedge clk);
    press(1, "t3_p2", e(0, 0, 0, 1, 0));
    press(2, "t3_p3", e(0, 0, 0, 2, 0));
    press(0, "t3_p4", e(0, 0, 0, 3, 0));
    press(0, "t3_p5", e(0, 0, 0, 4, 0));
    chk("t3_open", e(1, 0, 0, 4, 0));
    // program new code 2,0,1,1
    act('0, 1'b0, 1'b1, "t4_prog", e(1, 0, 0, 0, 0));
    press(2, "t4_w1", e(1, 0, 0, 1, 0));
    press(0, "t4_w2", e(1, 0, 0, 2, 0));
    press(1, "t4_w3", e(1, 0, 0, 3, 0));
    press(1, "t4_commit", e(0, 0, 0, 0, 0));
    press(1, "t4_o1", e(0, 0, 0, 1, 0));
    press(2, "t4_o2", e(0, 0, 0, 2, 0));
    press(0, "t4_o3", e(0, 0, 0, 3, 0));
    press(0, "t4_o4", e(0, 0, 0, 4, 0));
    chk("t4_oldfail", e(0, 1, 0, 4, 1));
    chk("t4_rearm", e(0, 0, 0, 0, 1));
    press(2, "t4_n1", e(0, 0, 0, 1, 1));
    press(0, "t4_n2", e(0, 0, 0, 2, 1));
    press(1, "t4_n3", e(0, 0, 0, 3, 1));
    press(1, "t4_n4", e(0, 0, 0, 4, 1));
    chk("t4_newopen", e(1, 0, 0, 4, 0));
    act('0, 1'b0, 1'b1, "t4_prog2", e(1, 0, 0, 0, 0));
    press(1, "t4_a1", e(1, 0, 0, 1, 0));
    press(2, "t4_a2", e(1, 0, 0, 2, 0));
    chk("t4_abort", e(1, 0, 0, 2, 0));
    chk("t4_rearm2", e(0, 0, 0, 0, 0));
    press(2, "t4_k1", e(0, 0, 0, 1, 0));
    press(0, "t4_k2", e(0, 0, 0, 2, 0));
    press(1, "t4_k3", e(0, 0, 0, 3, 0));
    press(1, "t4_k4", e(0, 0, 0, 4, 0));
    chk("t4_keptopen", e(1, 0, 0, 4, 0));
    chk("t4_rearm3", e(0, 0, 0, 0, 0));
    // multi-edge press spoils the entry; check drops a same-cycle btn edge
    act(3'b011, 1'b0, 1'b0, "t5_multi", e(0, 0, 0, 1, 0));
    press(0, "t5_p2", e(0, 0, 0, 2, 0));
    press(1, "t5_p3", e(0, 0, 0, 3, 0));
    press(1, "t5_p4", e(0, 0, 0, 4, 0));
    chk("t5_fail", e(0, 1, 0, 4, 1));
    chk("t5_rearm", e(0, 0, 0, 0, 1));
    press(2, "t5_p5", e(0, 0, 0, 1, 1));
    act(3'b001, 1'b1, 1'b0, "t5_drop", e(0, 1, 0, 1, 2));
    chk("t5_rearm2", e(0, 0, 0, 0, 2));
    // clr mid-entry
    press(2, "t6_p1", e(0, 0, 0, 1, 2));
    press(0, "t6_p2", e(0, 0, 0, 2, 2));
    pulse_clr("t6_clr_entry");
    // clr mid-lockout
    chk("t6_f1", e(0, 1, 0, 0, 1));
    chk("t6_r1", e(0, 0, 0, 0, 1));
    chk("t6_f2", e(0, 1, 0, 0, 2));
    chk("t6_r2", e(0, 0, 0, 0, 2));
    check = 1'b1;
    expect_next("t6_lock", e(0, 1, 1, 0, 3));
    check = 1'b0;
    repeat (4) @(negedge clk);
    pulse_clr("t6_clr_lock");
    // clr mid-program restores the default code
    press(1, "t6_d1", e(0, 0, 0, 1, 0));
    press(2, "t6_d2", e(0, 0, 0, 2, 0));
    press(0, "t6_d3", e(0, 0, 0, 3, 0));
    press(0, "t6_d4", e(0, 0, 0, 4, 0));
    chk("t6_open", e(1, 0, 0, 4, 0));
    act('0, 1'b0, 1'b1, "t6_prog", e(1, 0, 0, 0, 0));
    press(0, "t6_w1", e(1, 0, 0, 1, 0));
    press(0, "t6_w2", e(1, 0, 0, 2, 0));
    pulse_clr("t6_clr_prog");
    press(1, "t6_e1", e(0, 0, 0, 1, 0));
    press(2, "t6_e2", e(0, 0, 0, 2, 0));
    press(0, "t6_e3", e(0, 0, 0, 3, 0));
    press(0, "t6_e4", e(0, 0, 0, 4, 0));
    chk("t6_defopen", e(1, 0, 0, 4, 0));
    chk("t6_rearm", e(0, 0, 0, 0, 0));
    // button held through clr gives no press
    btn = 3'b010;
    repeat (3) @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
    repeat (3) @(negedge clk);
    expect_next("t6_held", e(0, 0, 0, 0, 0));
    btn = '0;
    repeat (25) @(negedge clk);
    press(1, "t6_after", e(0, 0, 0, 1, 0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
